// File: rtl/des_pkg.sv
// Shared DES constants: S-box tables, P permutation and datapath widths.
// With DES_F_LASTROUND_EN defined, beats carry a last-round flag.
package des_pkg;

  localparam int DATA_W = 32;
  localparam int EXP_W  = 48;

  // Entry index = row*16 + col; entry 0 sits at the MSB so each row reads left to right.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // DES bit numbering: output bit i+1 takes input bit P_TAB[i] (1 = MSB).
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  typedef struct packed {
    logic [EXP_W-1:0]  x;
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
`ifdef DES_F_LASTROUND_EN
    logic              last;
`endif
  } beat_t;

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] g);
    logic [5:0] idx;
    idx = {g[5], g[0], g[4:1]};
    return SBOX[box][255 - 4*int'(idx) -: 4];
  endfunction

endpackage

// File: rtl/des_sbox_p.sv
// Combinational DES S-box substitution followed by the P permutation.
module des_sbox_p
  import des_pkg::*;
(
  input  logic [EXP_W-1:0]  x,
  output logic [DATA_W-1:0] f
);

  logic [DATA_W-1:0] s;

  for (genvar j = 0; j < 8; j++) begin : g_box
    assign s[DATA_W-1-4*j -: 4] = sbox_lookup(3'(j), x[EXP_W-1-6*j -: 6]);
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_p
    assign f[DATA_W-1-i] = s[DATA_W-P_TAB[i]];
  end

endmodule

// File: rtl/des_f_round.sv
// Pipelined DES Feistel round: key XOR, S/P f-function and L/R swap, valid/ready both sides.
// Optional DES_F_LASTROUND_EN adds in_last; last beats leave unswapped.
module des_f_round
  import des_pkg::*;
#(
  parameter bit STAGE1_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXP_W-1:0]  in_er,
  input  logic [EXP_W-1:0]  in_k,
  input  logic [DATA_W-1:0] in_l,
  input  logic [DATA_W-1:0] in_r,
`ifdef DES_F_LASTROUND_EN
  input  logic              in_last,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_l,
  output logic [DATA_W-1:0] out_r
);

  beat_t             in_beat, st_beat;
  logic              st_valid, s2_ready;
  logic [DATA_W-1:0] f, nxt_l, nxt_r;

  always_comb begin
    in_beat   = '0;
    in_beat.x = in_er ^ in_k;
    in_beat.l = in_l;
    in_beat.r = in_r;
`ifdef DES_F_LASTROUND_EN
    in_beat.last = in_last;
`endif
  end

  assign s2_ready = !out_valid || out_ready;

  if (STAGE1_EN) begin : g_s1
    logic  s1_valid;
    beat_t s1_beat;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_beat  <= '0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_beat <= in_beat;
      end
    end

    assign in_ready = !s1_valid || s2_ready;
    assign st_valid = s1_valid;
    assign st_beat  = s1_beat;
  end else begin : g_s1_bypass
    assign in_ready = s2_ready;
    assign st_valid = in_valid;
    assign st_beat  = in_beat;
  end

  des_sbox_p u_sbox_p (
    .x (st_beat.x),
    .f (f)
  );

  always_comb begin
    nxt_l = st_beat.r;
    nxt_r = st_beat.l ^ f;
`ifdef DES_F_LASTROUND_EN
    // Round 16 skips the swap so the result feeds the inverse IP directly.
    if (st_beat.last) begin
      nxt_l = st_beat.l ^ f;
      nxt_r = st_beat.r;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
    end else if (s2_ready) begin
      out_valid <= st_valid;
      if (st_valid) begin
        out_l <= nxt_l;
        out_r <= nxt_r;
      end
    end
  end

endmodule

// File: tb/tb_des_f_round.sv
// Directed bench for des_f_round (default STAGE1_EN = 1, 2-cycle latency).
// Build with DES_F_LASTROUND_EN defined to also exercise the unswapped last round.
module tb_des_f_round;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [47:0] in_er = '0, in_k = '0;
  logic [31:0] in_l = '0, in_r = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_l, out_r;

  int errors = 0;
  int checks = 0;

  // f for x = 6117BA866527 (textbook round 1), x = 0, x = all ones
  logic [47:0] er_t [3];
  logic [47:0] k_t  [3];
  logic [31:0] f_t  [3];

  always #5 clk = ~clk;

  des_f_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_er     (in_er),
    .in_k      (in_k),
    .in_l      (in_l),
    .in_r      (in_r),
`ifdef DES_F_LASTROUND_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to the next sample point, one time unit after the falling edge.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int sel, input logic [31:0] l, input logic [31:0] r,
                       input logic last);
    in_valid = v;
    in_er    = er_t[sel];
    in_k     = k_t[sel];
    in_l     = l;
    in_r     = r;
    in_last  = last;
  endtask

  task automatic one_beat(input string tag, input int sel, input logic [31:0] l, input logic [31:0] r,
                          input logic last, input logic [31:0] exp_l, input logic [31:0] exp_r);
    drive(1'b1, sel, l, r, last);
    step();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_l"}, out_l, exp_l);
    chk({tag, "_r"}, out_r, exp_r);
    step();
    chk({tag, "_nodup"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] bl(input int c);
    return {8'(c), 24'hA5C3E1};
  endfunction

  function automatic logic [31:0] br(input int c);
    return {24'h3C5A96, 8'(c)};
  endfunction

  initial begin
    er_t[0] = 48'h7A15557A1555; k_t[0] = 48'h1B02EFFC7072; f_t[0] = 32'h234AA9BB;
    er_t[1] = 48'h123456789ABC; k_t[1] = 48'h123456789ABC; f_t[1] = 32'hD8D8DBBC;
    er_t[2] = 48'h123456789ABC; k_t[2] = 48'hEDCBA9876543; f_t[2] = 32'h38DBF9CB;

    // Reset state
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_l", out_l, 32'h0);
    chk("rst_r", out_r, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // Textbook round and S-box corners (L = 0 exposes f directly)
    one_beat("single", 0, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'hF0AAF0AA, 32'hEF4A6544);
    one_beat("x_zero", 1, 32'h0, 32'h13579BDF, 1'b0, 32'h13579BDF, 32'hD8D8DBBC);
    one_beat("x_ones", 2, 32'h0, 32'h2468ACE0, 1'b0, 32'h2468ACE0, 32'h38DBF9CB);

    // Back-to-back: 16 beats, one output per cycle in order
    for (int c = 0; c < 18; c++) begin
      if (c >= 2) begin
        chk($sformatf("b2b%0d_valid", c-2), 32'(out_valid), 32'd1);
        chk($sformatf("b2b%0d_l", c-2), out_l, br(c-2));
        chk($sformatf("b2b%0d_r", c-2), out_r, bl(c-2) ^ f_t[(c-2)%3]);
      end
      if (c < 16) begin
        chk($sformatf("b2b%0d_in_ready", c), 32'(in_ready), 32'd1);
        drive(1'b1, c % 3, bl(c), br(c), 1'b0);
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    chk("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: out_ready low for 5 cycles while offering 3 beats
    out_ready = 1'b0;
    drive(1'b1, 0, bl(100), br(100), 1'b0);
    step();
    drive(1'b1, 1, bl(101), br(101), 1'b0);
    step();
    drive(1'b1, 2, bl(102), br(102), 1'b0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_hold%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("bp_hold%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_l", c), out_l, br(100));
      chk($sformatf("bp_hold%0d_r", c), out_r, bl(100) ^ f_t[0]);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_out%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp_out%0d_l", c), out_l, br(100+c));
      chk($sformatf("bp_out%0d_r", c), out_r, bl(100+c) ^ f_t[c]);
      step();
      in_valid = 1'b0;
    end
    chk("bp_drain", 32'(out_valid), 32'd0);

    // Async reset with two beats in flight
    drive(1'b1, 0, bl(200), br(200), 1'b0);
    step();
    drive(1'b1, 1, bl(201), br(201), 1'b0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("ar_inflight_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_l", out_l, 32'h0);
    chk("ar_r", out_r, 32'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("ar_stale%0d", c), 32'(out_valid), 32'd0);
    end
    chk("ar_in_ready", 32'(in_ready), 32'd1);

`ifdef DES_F_LASTROUND_EN
    one_beat("last", 0, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b1, 32'hEF4A6544, 32'hF0AAF0AA);
    one_beat("not_last", 0, 32'hCC00CCFF, 32'hF0AAF0AA, 1'b0, 32'hF0AAF0AA, 32'hEF4A6544);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
